frac_block_feeder: RTL and testbench

Front-end sequencer for the fractional-pel search. On a start command it fetches one 8x8 filter block and the co-located reference rows from two synchronous pixel RAMs, then streams them one row per cycle into frac_search. It then captures the six candidate SADs, selects the minimum, and reports the winning candidate index with a done pulse.

---
 rtl/frac_pkg.sv | 20 ++
 rtl/sad_argmin6.sv | 25 ++
 rtl/frac_block_feeder.sv | 142 ++++++++++++++
 tb/tb_frac_block_feeder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/frac_pkg.sv
// Shared definitions for the fractional-pel search front end.
package frac_pkg;

  // Rows in one filter block and number of fractional candidates scored.
  localparam int BLK_ROWS  = 8;
  localparam int NUM_CAND  = 6;

  // Default width of one candidate SAD.
  localparam int SAD_W_DEF = 10;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

endpackage

// File: rtl/sad_argmin6.sv
// Six-way unsigned minimum; ties resolve to the lowest candidate index.
module sad_argmin6
  import frac_pkg::*;
#(
  parameter int SAD_W = SAD_W_DEF
) (
  input  logic [NUM_CAND*SAD_W-1:0] sads,
  output logic [2:0]                idx,
  output logic [SAD_W-1:0]          value
);

  // Linear scan; strict less-than keeps the earliest index on a tie.
  always_comb begin
    // NOTE: every output gets a default before any conditional update so no latch is inferred.
    idx   = 3'd0;
    value = sads[0 +: SAD_W];
    for (int k = 1; k < NUM_CAND; k++) begin
      if (sads[k*SAD_W +: SAD_W] < value) begin
        idx   = 3'(k);
        value = sads[k*SAD_W +: SAD_W];
      end
    end
  end

endmodule

// File: rtl/frac_block_feeder.sv
// Fetches one 8x8 filter block plus co-located reference rows, streams them
// to frac_search one row per cycle, then reports the best of six SADs.
module frac_block_feeder
  import frac_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_W     = 12,
  parameter int SAD_W      = SAD_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                blk_x,
  input  logic [7:0]                blk_y,
  output logic                      busy,
  output logic                      flt_rd,
  output logic [ADDR_W-1:0]         flt_addr,
  input  logic [63:0]               flt_data,
  output logic                      ref_rd,
  output logic [ADDR_W-1:0]         ref_addr,
  input  logic [63:0]               ref_data,
  output logic [63:0]               filter_pix,
  output logic [47:0]               ref_pix,
  output logic                      input_ready,
  input  logic [NUM_CAND*SAD_W-1:0] sad_out,
  output logic                      done,
  output logic [2:0]                best_idx,
  output logic [SAD_W-1:0]          best_sad
);

  state_t                    state, state_nxt;
  logic [7:0]                blk_x_q, blk_y_q;
  logic [2:0]                row_cnt;
  logic                      fetch;
  logic                      rd_d;
  logic [ADDR_W-1:0]         row_addr;
  logic [NUM_CAND*SAD_W-1:0] sad_q;
  logic [2:0]                best_idx_q, cmp_idx;
  logic [SAD_W-1:0]          best_sad_q, cmp_sad;
  logic                      unused_ref_edge;

  // Only the inner six reference pixels feed the search.
  assign unused_ref_edge = ^{ref_data[63:56], ref_data[7:0]};

  // Frame address of the current row; overflow simply wraps.
  assign row_addr = ADDR_W'((32'(blk_y_q) * BLK_ROWS + 32'(row_cnt)) * LINE_WORDS
                            + 32'(blk_x_q));

  // State register plus the block position latched at start acceptance.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state   <= ST_IDLE;
      blk_x_q <= '0;
      blk_y_q <= '0;
      row_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        blk_x_q <= blk_x;
        blk_y_q <= blk_y;
        row_cnt <= '0;
      end else if (state == ST_FETCH) begin
        row_cnt <= row_cnt + 3'd1;
      end
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    fetch     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    best_idx  = best_idx_q;
    best_sad  = best_sad_q;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        fetch = 1'b1;
        busy  = 1'b1;
        if (row_cnt == 3'(BLK_ROWS - 1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Last streamed row is on the bus and nothing is left in the RAM pipe.
        if (input_ready && !rd_d) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        busy      = 1'b1;
        state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        // Result is visible during the done cycle and held afterwards.
        done      = 1'b1;
        best_idx  = cmp_idx;
        best_sad  = cmp_sad;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign flt_rd   = fetch;
  assign ref_rd   = fetch;
  assign flt_addr = fetch ? row_addr : '0;
  assign ref_addr = fetch ? row_addr : '0;

  // RAM-latency pipeline, row capture, SAD sampling and result hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d        <= 1'b0;
      input_ready <= 1'b0;
      filter_pix  <= '0;
      ref_pix     <= '0;
      sad_q       <= '0;
      best_idx_q  <= '0;
      best_sad_q  <= '0;
    end else begin
      rd_d        <= fetch;
      input_ready <= rd_d;
      if (rd_d) begin
        filter_pix <= flt_data;
        ref_pix    <= ref_data[55:8];
      end
      if (state == ST_SAMPLE) sad_q <= sad_out;
      if (state == ST_REPORT) begin
        best_idx_q <= cmp_idx;
        best_sad_q <= cmp_sad;
      end
    end
  end

  sad_argmin6 #(.SAD_W(SAD_W)) u_argmin (
    .sads  (sad_q),
    .idx   (cmp_idx),
    .value (cmp_sad)
  );

endmodule

// File: tb/tb_frac_block_feeder.sv
// Self-checking bench: directed vector table, reset corner cases and random blocks.
module tb_frac_block_feeder;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  blk_x, blk_y;
  logic        busy, flt_rd, ref_rd, input_ready, done;
  logic [11:0] flt_addr, ref_addr;
  logic [63:0] flt_data, ref_data, filter_pix;
  logic [47:0] ref_pix;
  logic [59:0] sad_out;
  logic [2:0]  best_idx;
  logic [9:0]  best_sad;

  // Second instance with a 6-bit address space to exercise wrapping.
  logic        unused_dw_busy, unused_dw_flt_rd, unused_dw_ref_rd, unused_dw_ready;
  logic [5:0]  dw_flt_addr, dw_ref_addr;
  logic [63:0] unused_dw_filter_pix;
  logic [47:0] unused_dw_ref_pix;
  logic        dw_done;
  logic [2:0]  dw_best_idx;
  logic [9:0]  unused_dw_best_sad;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frac_block_feeder #(.LINE_WORDS(8), .ADDR_W(12), .SAD_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .blk_x(blk_x), .blk_y(blk_y),
    .busy(busy), .flt_rd(flt_rd), .flt_addr(flt_addr), .flt_data(flt_data),
    .ref_rd(ref_rd), .ref_addr(ref_addr), .ref_data(ref_data),
    .filter_pix(filter_pix), .ref_pix(ref_pix), .input_ready(input_ready),
    .sad_out(sad_out), .done(done), .best_idx(best_idx), .best_sad(best_sad)
  );

  frac_block_feeder #(.LINE_WORDS(8), .ADDR_W(6), .SAD_W(10)) dw (
    .clk(clk), .reset(reset), .start(start), .blk_x(blk_x), .blk_y(blk_y),
    .busy(unused_dw_busy), .flt_rd(unused_dw_flt_rd), .flt_addr(dw_flt_addr),
    .flt_data(flt_data), .ref_rd(unused_dw_ref_rd), .ref_addr(dw_ref_addr),
    .ref_data(ref_data), .filter_pix(unused_dw_filter_pix), .ref_pix(unused_dw_ref_pix),
    .input_ready(unused_dw_ready), .sad_out(sad_out), .done(dw_done),
    .best_idx(dw_best_idx), .best_sad(unused_dw_best_sad)
  );

  // ---------------- reference model ----------------
  function automatic int m_addr(int bx, int by, int r, int aw);
    return ((by * 8 + r) * 8 + bx) % (1 << aw);
  endfunction

  function automatic logic [63:0] flt_word(int a);
    return {8{a[7:0]}};
  endfunction

  function automatic logic [63:0] ref_word(int a);
    return {8{a[7:0]}} ^ 64'hF0E1_D2C3_B4A5_9687;
  endfunction

  function automatic logic [59:0] pack6(int c0, int c1, int c2, int c3, int c4, int c5);
    return {10'(c5), 10'(c4), 10'(c3), 10'(c2), 10'(c1), 10'(c0)};
  endfunction

  // Smallest value first, then the first candidate holding it.
  function automatic void m_argmin(input logic [59:0] s, output int idx, output int val);
    int v[6];
    for (int k = 0; k < 6; k++) v[k] = int'(s[k*10 +: 10]);
    val = 1023;
    for (int k = 0; k < 6; k++) if (v[k] < val) val = v[k];
    idx = 0;
    while (v[idx] != val) idx++;
  endfunction

  // Synchronous RAM models, one cycle read latency.
  always @(posedge clk) begin
    if (flt_rd) flt_data <= flt_word(int'(flt_addr));
    if (ref_rd) ref_data <= ref_word(int'(ref_addr));
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues start in the current cycle (T0) and checks every cycle up to T13.
  task automatic run_block(input int bx, input int by, input logic [59:0] sads,
                           input int exp_idx, input int exp_sad, input bit poke);
    logic [63:0] rw;
    bit exp_rd, exp_rdy;
    int r;
    start = 1'b1;
    blk_x = 8'(bx);
    blk_y = 8'(by);
    tick();
    for (int c = 1; c <= 12; c++) begin
      start   = (poke && c == 5);
      blk_x   = 8'($urandom);
      blk_y   = 8'($urandom);
      sad_out = (c == 11) ? sads : {28'($urandom), 32'($urandom)};
      exp_rd  = (c <= 8);
      exp_rdy = (c >= 3 && c <= 10);
      check("busy", 64'(busy), 64'(c <= 11));
      check("flt_rd", 64'(flt_rd), 64'(exp_rd));
      check("ref_rd", 64'(ref_rd), 64'(exp_rd));
      check("flt_addr", 64'(flt_addr), exp_rd ? 64'(m_addr(bx, by, c - 1, 12)) : 64'd0);
      check("ref_addr", 64'(ref_addr), exp_rd ? 64'(m_addr(bx, by, c - 1, 12)) : 64'd0);
      check("wrap_addr", 64'(dw_flt_addr), exp_rd ? 64'(m_addr(bx, by, c - 1, 6)) : 64'd0);
      check("wrap_ref_addr", 64'(dw_ref_addr), exp_rd ? 64'(m_addr(bx, by, c - 1, 6)) : 64'd0);
      check("input_ready", 64'(input_ready), 64'(exp_rdy));
      if (exp_rdy) begin
        r  = m_addr(bx, by, c - 3, 12);
        rw = ref_word(r);
        check("filter_pix", filter_pix, flt_word(r));
        check("ref_pix", 64'(ref_pix), 64'(rw[55:8]));
      end
      check("done", 64'(done), 64'(c == 12));
      check("wrap_done", 64'(dw_done), 64'(c == 12));
      if (c == 12) begin
        check("best_idx", 64'(best_idx), 64'(exp_idx));
        check("best_sad", 64'(best_sad), 64'(exp_sad));
        check("wrap_best_idx", 64'(dw_best_idx), 64'(exp_idx));
      end
      tick();
    end
    start = 1'b0;
    // T13: idle again, result held, last row still on the pixel bus.
    check("done_t13", 64'(done), 64'd0);
    check("busy_t13", 64'(busy), 64'd0);
    check("best_idx_hold", 64'(best_idx), 64'(exp_idx));
    check("best_sad_hold", 64'(best_sad), 64'(exp_sad));
    check("pix_hold", filter_pix, flt_word(m_addr(bx, by, 7, 12)));
  endtask

  typedef struct {
    int          bx;
    int          by;
    logic [59:0] sads;
    int          exp_idx;
    int          exp_sad;
    bit          poke;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ri, rs;
    logic [59:0] s;

    vecs[0] = '{1,   0,   pack6(300, 120, 500, 120, 999, 121), 1, 120,  1'b0};
    vecs[1] = '{1,   0,   pack6(1023, 1023, 1023, 1023, 1023, 1023), 0, 1023, 1'b1};
    vecs[2] = '{3,   7,   pack6(50, 40, 30, 20, 10, 10), 4, 10,   1'b0};
    vecs[3] = '{255, 255, pack6(0, 5, 5, 5, 5, 0),       0, 0,    1'b1};
    vecs[4] = '{0,   0,   pack6(7, 7, 7, 7, 7, 6),       5, 6,    1'b0};

    // Reset with a coincident start: reset wins.
    reset   = 1'b1;
    start   = 1'b1;
    blk_x   = 8'd9;
    blk_y   = 8'd4;
    sad_out = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd", 64'({flt_rd, ref_rd}), 64'd0);
    check("rst_addr", 64'({flt_addr, ref_addr}), 64'd0);
    check("rst_pix", filter_pix, 64'd0);
    check("rst_ref_pix", 64'(ref_pix), 64'd0);
    check("rst_ready", 64'(input_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_best", 64'({best_idx, best_sad}), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("start_in_reset_ignored", 64'(busy), 64'd0);

    // Directed table, issued back to back at full throughput.
    for (int i = 0; i < 5; i++)
      run_block(vecs[i].bx, vecs[i].by, vecs[i].sads, vecs[i].exp_idx,
                vecs[i].exp_sad, vecs[i].poke);

    // Reset in T4 of a fetch; restart in T6.
    start = 1'b1;
    blk_x = 8'd2;
    blk_y = 8'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("midrst_t4_rd", 64'(flt_rd), 64'd1);
    check("midrst_t4_addr", 64'(flt_addr), 64'(m_addr(2, 1, 3, 12)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_t5_rd", 64'({flt_rd, ref_rd}), 64'd0);
    check("midrst_t5_ready", 64'(input_ready), 64'd0);
    check("midrst_t5_busy", 64'(busy), 64'd0);
    check("midrst_t5_done", 64'(done), 64'd0);
    check("midrst_t5_best", 64'({best_idx, best_sad}), 64'd0);
    tick();
    check("midrst_t6_ready", 64'(input_ready), 64'd0);
    check("midrst_t6_done", 64'(done), 64'd0);
    run_block(5, 2, pack6(9, 8, 7, 3, 3, 4), 3, 3, 1'b0);

    // Random blocks with tie-prone SAD sets.
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 6; k++)
        s[k*10 +: 10] = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 3))
                                                    : 10'($urandom);
      m_argmin(s, ri, rs);
      run_block(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), s, ri, rs,
                1'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
